loop_ctrl: RTL and testbench

Parametrised hardware-loop controller for the LMA0 fetch path. Decodes LCG (loop) instructions as they issue, keeps a nested-loop stack of body bounds and iteration counts, and tells fetch either to replay the instruction held in IR (single-instruction body) or to redirect the PC back to the body start. It terminates loops on count exhaustion or on the external loop condition, and it supersedes the combinational LCG/loop-condition select.

---
 rtl/loop_ctrl_pkg.sv | 30 +++
 rtl/loop_ctrl_stack.sv | 68 ++++++
 rtl/loop_ctrl.sv | 126 ++++++++++++
 tb/tb_loop_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/loop_ctrl_pkg.sv
//============================================================================
// loop_ctrl_pkg : shared constants and loop-stack entry type  (rev 1.0)
//============================================================================
`default_nettype none

package loop_ctrl_pkg;

  localparam int         OPC_W      = 7;
  localparam logic [6:0] LCG_OPCODE = 7'b0000100;

  localparam int LC_INSTR_W = 16;
  localparam int LC_PC_W    = 8;
  localparam int LC_LEN_W   = 4;
  localparam int LC_COUNT_W = LC_INSTR_W - OPC_W - LC_LEN_W;

  localparam int LEN_LSB = OPC_W;
  localparam int CNT_LSB = OPC_W + LC_LEN_W;

  typedef struct packed {
    logic [LC_PC_W-1:0]    start_pc;
    logic [LC_PC_W-1:0]    end_pc;
    logic [LC_COUNT_W-1:0] rem;
`ifdef LOOP_CTRL_COND_MODE_EN
    logic                  cmode;
`endif
  } loop_entry_t;

endpackage

`default_nettype wire

// File: rtl/loop_ctrl_stack.sv
//============================================================================
// loop_ctrl_stack : LIFO of loop entries with push, pop and top rewrite (rev 1.0)
//============================================================================
`default_nettype none

module loop_ctrl_stack
  import loop_ctrl_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         top_wr_i,
  input  loop_entry_t                  push_entry_i,
  input  loop_entry_t                  top_entry_i,
  output loop_entry_t                  top_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  loop_entry_t      entries_q [DEPTH];
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic [IDX_W-1:0] w_top_idx;
  logic [IDX_W-1:0] w_push_idx;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign w_top_idx  = IDX_W'(count_q - CNT_W'(1));
  assign w_push_idx = IDX_W'(count_q);
  // An empty stack reads as all-zero so loop_iter naturally reports 0.
  assign top_o      = empty_o ? '0 : entries_q[w_top_idx];
  assign count_o    = count_q;

  always_comb begin
    count_d = count_q;
    if (push_i && !full_o) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop_i && !empty_o) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (push_i && !full_o) begin
        entries_q[w_push_idx] <= push_entry_i;
      end else if (top_wr_i && !empty_o) begin
        entries_q[w_top_idx] <= top_entry_i;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/loop_ctrl.sv
//============================================================================
// loop_ctrl : hardware-loop controller (LCG decode, end evaluation, replay/redirect).
// Optional condition mode: LOOP_CTRL_COND_MODE_EN                       (rev 1.0)
//============================================================================
`default_nettype none

module loop_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int INSTR_W = LC_INSTR_W,
  parameter int PC_W    = LC_PC_W,
  parameter int LEN_W   = LC_LEN_W,
  parameter int DEPTH   = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              instr_valid,
  input  logic [INSTR_W-1:0]                instr,
  input  logic [PC_W-1:0]                   pc,
  input  logic                              loop_cond,
  output logic                              sel,
  output logic                              redirect,
  output logic [PC_W-1:0]                   redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0]        loop_depth,
  output logic [INSTR_W-OPC_W-LEN_W-1:0]    loop_iter,
  output logic                              err
);

  localparam int COUNT_W = INSTR_W - OPC_W - LEN_W;

  logic [LEN_W-1:0]           w_len;
  logic [COUNT_W-1:0]         w_cnt;
  loop_entry_t                w_top;
  loop_entry_t                w_new;
  loop_entry_t                w_top_upd;
  logic [$clog2(DEPTH+1)-1:0] w_count;
  logic w_full, w_empty, w_is_lcg, w_end_hit, w_cmode_top;
  logic w_continue, w_push, w_pop, w_top_wr;

  logic            sel_q, sel_d;
  logic            redirect_q, redirect_d;
  logic            err_q, err_d;
  logic [PC_W-1:0] rpc_q, rpc_d;

  assign w_len    = instr[LEN_LSB +: LEN_W];
  assign w_cnt    = instr[INSTR_W-1 -: COUNT_W];
  assign w_is_lcg = instr_valid && (instr[OPC_W-1:0] == LCG_OPCODE);

  always_comb begin
    w_new          = '0;
    w_new.start_pc = pc + PC_W'(1);
    w_new.end_pc   = pc + PC_W'(1) + PC_W'(w_len);
`ifdef LOOP_CTRL_COND_MODE_EN
    w_new.rem      = w_cnt;
    w_new.cmode    = (w_cnt == '0);
`else
    w_new.rem      = (w_cnt == '0) ? COUNT_W'(1) : w_cnt;
`endif
  end

`ifdef LOOP_CTRL_COND_MODE_EN
  assign w_cmode_top = w_top.cmode;
`else
  assign w_cmode_top = 1'b0;
`endif

  // Only the innermost loop is evaluated, even if an outer body ends on the same PC.
  assign w_end_hit  = instr_valid && !w_empty && (pc == w_top.end_pc);
  assign w_continue = w_end_hit && !loop_cond &&
                      (w_cmode_top || (w_top.rem > COUNT_W'(1)));
  assign w_pop      = w_end_hit && !w_continue;
  assign w_top_wr   = w_continue && !w_cmode_top;
  // An LCG sitting on the current body end is rejected; end evaluation still runs.
  assign w_push     = w_is_lcg && !w_full && !w_end_hit;

  always_comb begin
    w_top_upd     = w_top;
    w_top_upd.rem = w_top.rem - COUNT_W'(1);
  end

  loop_ctrl_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk          (clk),
    .rst_n        (rst_n),
    .push_i       (w_push),
    .pop_i        (w_pop),
    .top_wr_i     (w_top_wr),
    .push_entry_i (w_new),
    .top_entry_i  (w_top_upd),
    .top_o        (w_top),
    .count_o      (w_count),
    .full_o       (w_full),
    .empty_o      (w_empty)
  );

  // Single-instruction bodies have start_pc == end_pc and are replayed from IR.
  assign sel_d      = w_continue && (w_top.start_pc == w_top.end_pc);
  assign redirect_d = w_continue && (w_top.start_pc != w_top.end_pc);
  assign rpc_d      = redirect_d ? w_top.start_pc : rpc_q;
  assign err_d      = err_q | (w_is_lcg && (w_full || w_end_hit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      err_q      <= err_d;
    end
  end

  assign sel         = sel_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign err         = err_q;
  assign loop_depth  = w_count;
  assign loop_iter   = w_top.rem;

endmodule

`default_nettype wire

// File: tb/tb_loop_ctrl.sv
//============================================================================
// tb_loop_ctrl : queue-based reference model, per-cycle compare, directed + random stimulus
//============================================================================
`default_nettype none

module tb_loop_ctrl;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic [7:0]  pc = 8'h00;
  logic        loop_cond = 1'b0;
  logic        sel, redirect, err;
  logic [7:0]  redirect_pc;
  logic [1:0]  loop_depth;
  logic [4:0]  loop_iter;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  loop_ctrl #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .loop_cond   (loop_cond),
    .sel         (sel),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .loop_depth  (loop_depth),
    .loop_iter   (loop_iter),
    .err         (err)
  );

  typedef struct {
    int start_pc;
    int end_pc;
    int len;
    int rem;
    bit cmode;
  } ment_t;

  ment_t m_stk[$];
  ment_t m_t;
  bit    m_sel = 0, m_red = 0, m_err = 0;
  int    m_rpc = 0;
  bit    m_hit, m_lcg;
  int    m_l, m_n;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: loop stack as a queue, evaluated per issued instruction.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stk.delete();
      m_sel = 0; m_red = 0; m_rpc = 0; m_err = 0;
    end else begin
      m_sel = 0; m_red = 0;
      if (instr_valid) begin
        m_lcg = (instr[6:0] == 7'b0000100);
        m_l   = int'(instr[10:7]);
        m_n   = int'(instr[15:11]);
        m_hit = (m_stk.size() > 0) && (int'(pc) == m_stk[m_stk.size()-1].end_pc);
        if (m_lcg) begin
          if (m_hit || m_stk.size() >= DEPTH) m_err = 1;
          else begin
            m_t.start_pc = (int'(pc) + 1) % 256;
            m_t.end_pc   = (int'(pc) + 1 + m_l) % 256;
            m_t.len      = m_l;
`ifdef LOOP_CTRL_COND_MODE_EN
            m_t.cmode = (m_n == 0);
            m_t.rem   = m_n;
`else
            m_t.cmode = 0;
            m_t.rem   = (m_n == 0) ? 1 : m_n;
`endif
            m_stk.push_back(m_t);
          end
        end
        if (m_hit) begin
          m_t = m_stk.pop_back();
          if (!loop_cond && (m_t.cmode || m_t.rem > 1)) begin
            if (!m_t.cmode) m_t.rem = m_t.rem - 1;
            m_stk.push_back(m_t);
            if (m_t.len == 0) m_sel = 1;
            else begin m_red = 1; m_rpc = m_t.start_pc; end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("sel", int'(sel), int'(m_sel));
      chk("redirect", int'(redirect), int'(m_red));
      if (m_red) chk("redirect_pc", int'(redirect_pc), m_rpc);
      chk("loop_depth", int'(loop_depth), m_stk.size());
      chk("loop_iter", int'(loop_iter), (m_stk.size() > 0) ? m_stk[m_stk.size()-1].rem : 0);
      chk("err", int'(err), int'(m_err));
    end
  end

  function automatic logic [15:0] lcg(input int l, input int n);
    logic [15:0] r;
    r = {n[4:0], l[3:0], 7'b0000100};
    return r;
  endfunction

  task automatic issue(input bit v, input logic [15:0] ins, input int p, input bit c);
    @(negedge clk); #1;
    instr_valid = v; instr = ins; pc = p[7:0]; loop_cond = c;
    @(posedge clk); #2;
  endtask

  task automatic body(input int p);
    issue(1, 16'h0000, p, 0);
  endtask

  int n_pass;

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_on = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_sel", int'(sel), 0);
    chk("rst_redirect", int'(redirect), 0);
    chk("rst_redirect_pc", int'(redirect_pc), 0);
    chk("rst_depth", int'(loop_depth), 0);
    chk("rst_iter", int'(loop_iter), 0);
    chk("rst_err", int'(err), 0);
    @(negedge clk); #1 rst_n = 1'b1;

    // L=2, N=3 at 0x10, with a bubble carrying the end PC
    issue(1, lcg(2, 3), 8'h10, 0);
    chk("t1_depth", int'(loop_depth), 1);
    chk("t1_iter", int'(loop_iter), 3);
    for (int k = 0; k < 3; k++) begin
      body(8'h11); body(8'h12);
      if (k == 0) begin
        issue(0, 16'h0000, 8'h13, 0);
        chk("t1_bubble_redirect", int'(redirect), 0);
      end
      issue(1, 16'h0000, 8'h13, 0);
      if (k < 2) begin
        chk("t1_redirect", int'(redirect), 1);
        chk("t1_redirect_pc", int'(redirect_pc), 8'h11);
        chk("t1_iter_dec", int'(loop_iter), 2 - k);
      end else begin
        chk("t1_last_redirect", int'(redirect), 0);
        chk("t1_pop_depth", int'(loop_depth), 0);
      end
    end

    // single-instruction body replay
    issue(1, lcg(0, 4), 8'h20, 0);
    for (int k = 0; k < 4; k++) begin
      body(8'h21);
      chk("t2_sel", int'(sel), (k < 3) ? 1 : 0);
      chk("t2_redirect", int'(redirect), 0);
    end
    chk("t2_depth", int'(loop_depth), 0);

    // N=0: condition mode when enabled, single pass otherwise
    issue(1, lcg(1, 0), 8'h30, 0);
`ifdef LOOP_CTRL_COND_MODE_EN
    n_pass = 5;
`else
    n_pass = 1;
`endif
    for (int k = 0; k < n_pass; k++) begin
      body(8'h31);
      issue(1, 16'h0000, 8'h32, (k == 4));
      chk("t3_redirect", int'(redirect), (k < n_pass - 1) ? 1 : 0);
    end
    chk("t3_depth", int'(loop_depth), 0);

    // early exit in count mode
    issue(1, lcg(2, 5), 8'h40, 0);
    body(8'h41); body(8'h42);
    issue(1, 16'h0000, 8'h43, 1);
    chk("t4_redirect", int'(redirect), 0);
    chk("t4_depth", int'(loop_depth), 0);
    chk("t4_iter", int'(loop_iter), 0);

    // nesting with overflow at DEPTH=2
    for (int op = 0; op < 2; op++) begin
      if (op == 0) issue(1, lcg(6, 2), 8'h00, 0);
      body(8'h01);
      issue(1, lcg(1, 3), 8'h02, 0);
      chk("t5_depth2", int'(loop_depth), 2);
      if (op == 0) begin
        issue(1, lcg(1, 1), 8'h03, 0);
        chk("t5_err", int'(err), 1);
        chk("t5_depth_hold", int'(loop_depth), 2);
      end else body(8'h03);
      body(8'h04);
      chk("t5_inner_rpc", int'(redirect_pc), 8'h03);
      for (int k = 0; k < 2; k++) begin body(8'h03); body(8'h04); end
      chk("t5_inner_pop", int'(loop_depth), 1);
      body(8'h05); body(8'h06); body(8'h07);
      chk("t5_outer_redirect", int'(redirect), (op == 0) ? 1 : 0);
      if (op == 0) chk("t5_outer_rpc", int'(redirect_pc), 8'h01);
    end
    chk("t5_depth_end", int'(loop_depth), 0);

    // reset in the middle of a nested body
    issue(1, lcg(6, 2), 8'h50, 0);
    issue(1, lcg(1, 3), 8'h52, 0);
    body(8'h53);
    @(negedge clk); #1;
    instr_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("t6_sel", int'(sel), 0);
    chk("t6_redirect", int'(redirect), 0);
    chk("t6_depth", int'(loop_depth), 0);
    chk("t6_iter", int'(loop_iter), 0);
    chk("t6_err", int'(err), 0);
    @(negedge clk); #1 rst_n = 1'b1;
    body(8'h54);
    chk("t6_no_stale", int'(redirect), 0);

    // LCG on the top body-end PC
    issue(1, lcg(1, 2), 8'h60, 0);
    body(8'h61);
    issue(1, lcg(0, 1), 8'h62, 0);
    chk("t7_err", int'(err), 1);
    chk("t7_depth", int'(loop_depth), 1);
    chk("t7_redirect", int'(redirect), 1);
    chk("t7_rpc", int'(redirect_pc), 8'h61);
    body(8'h61); body(8'h62);
    chk("t7_pop", int'(loop_depth), 0);

    // random traffic around the PC wrap point
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ins;
      logic [6:0]  opc;
      if (i % 500 == 499) begin
        @(negedge clk); #1 instr_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk); #1 rst_n = 1'b1;
      end
      if ($urandom_range(0, 3) == 0) ins = lcg($urandom_range(0, 3), $urandom_range(0, 5));
      else begin
        opc = 7'($urandom_range(0, 127));
        if (opc == 7'b0000100) opc = 7'b0000101;
        ins = {9'($urandom), opc};
      end
      issue($urandom_range(0, 3) != 0, ins, ($urandom_range(0, 15) + 248) % 256,
            $urandom_range(0, 4) == 0);
    end

    @(negedge clk); #1 instr_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
